// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the shared memory arbiter.
// The slave modport is the arbiter's view; the master modport is the caches and RAM.
interface mem_arbiter_if #(
    parameter int NCPU = 2
);
    logic [NCPU-1:0]      iREN;
    logic [NCPU-1:0]      dREN;
    logic [NCPU-1:0]      dWEN;
    logic [NCPU-1:0]      iwait;
    logic [NCPU-1:0]      dwait;
    logic [32*NCPU-1:0]   iaddr;
    logic [32*NCPU-1:0]   daddr;
    logic [32*NCPU-1:0]   dstore;
    logic [32*NCPU-1:0]   iload;
    logic [32*NCPU-1:0]   dload;
    logic                 ramREN;
    logic                 ramWEN;
    logic [31:0]          ramaddr;
    logic [31:0]          ramstore;
    logic [31:0]          ramload;
    logic [1:0]           ramstate;
    logic                 ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the icaches and dcaches of NCPU cores: dcache first,
// round-robin between cores, dcache grants locked for a whole block.
module mem_arbiter #(
    parameter int NCPU        = 2,
    parameter int BLOCK_WORDS = 2,
    parameter int IDLE_TMO    = 4
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    localparam int IW = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int WW = $clog2(BLOCK_WORDS + 1);
    localparam int TW = $clog2(IDLE_TMO + 1);

    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

    state_t          state;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   rr_next;
    logic [IW-1:0]   dwin;
    logic [IW-1:0]   iwin;
    logic [WW-1:0]   wcnt;
    logic [TW-1:0]   tmo;
    logic            ram_err_q;
    logic [31:0]     addr_hold;
    logic [31:0]     store_hold;
    logic [31:0]     addr_c;
    logic [31:0]     store_c;
    logic [NCPU-1:0] dreq;
    logic [NCPU-1:0] iwait_c;
    logic [NCPU-1:0] dwait_c;
    logic            dfound;
    logic            ifound;
    logic            ren;
    logic            wen;
    logic            strobe;
    logic            done;

    assign dreq    = bus.dREN | bus.dWEN;
    assign rr_next = (gidx == IW'(NCPU - 1)) ? '0 : gidx + IW'(1);

    // First requester at or above the round-robin pointer, wrapping.
    always_comb begin : pick
        logic [IW-1:0] idx;
        idx    = '0;
        dwin   = '0;
        iwin   = '0;
        dfound = 1'b0;
        ifound = 1'b0;
        for (int k = 0; k < NCPU; k++) begin
            idx = IW'((int'(rr) + k) % NCPU);
            if (!dfound && dreq[idx]) begin
                dfound = 1'b1;
                dwin   = idx;
            end
            if (!ifound && bus.iREN[idx]) begin
                ifound = 1'b1;
                iwin   = idx;
            end
        end
    end

    always_comb begin
        ren     = 1'b0;
        wen     = 1'b0;
        addr_c  = addr_hold;
        store_c = store_hold;
        case (state)
            DGNT: begin
                wen     = bus.dWEN[gidx];
                ren     = bus.dREN[gidx] & ~bus.dWEN[gidx];
                addr_c  = bus.daddr[32*gidx +: 32];
                store_c = bus.dstore[32*gidx +: 32];
            end
            IGNT: begin
                ren    = bus.iREN[gidx];
                addr_c = bus.iaddr[32*gidx +: 32];
            end
            default: ;
        endcase
    end

    assign strobe = ren | wen;
    assign done   = strobe && (bus.ramstate == 2'b10);

    always_comb begin
        iwait_c = '1;
        dwait_c = '1;
        if (done && state == IGNT) iwait_c[gidx] = 1'b0;
        if (done && state == DGNT) dwait_c[gidx] = 1'b0;
    end

    assign bus.ramREN   = ren;
    assign bus.ramWEN   = wen;
    assign bus.ramaddr  = addr_c;
    assign bus.ramstore = store_c;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = {NCPU{bus.ramload}};
    assign bus.dload    = {NCPU{bus.ramload}};
    assign bus.ram_err  = ram_err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            gidx       <= '0;
            rr         <= '0;
            wcnt       <= '0;
            tmo        <= '0;
            ram_err_q  <= 1'b0;
            addr_hold  <= '0;
            store_hold <= '0;
        end else begin
            if (state != IDLE && bus.ramstate == 2'b11) ram_err_q <= 1'b1;
            if (state != IDLE) begin
                addr_hold  <= addr_c;
                store_hold <= store_c;
            end
            case (state)
                IDLE: begin
                    if (dfound) begin
                        state <= DGNT;
                        gidx  <= dwin;
                        wcnt  <= '0;
                        tmo   <= '0;
                    end else if (ifound) begin
                        state <= IGNT;
                        gidx  <= iwin;
                    end
                end
                // The lock survives a dropped strobe until the idle timeout expires.
                DGNT: begin
                    if (strobe) begin
                        tmo <= '0;
                        if (done) begin
                            if (wcnt == WW'(BLOCK_WORDS - 1)) begin
                                state <= IDLE;
                                wcnt  <= '0;
                                rr    <= rr_next;
                            end else begin
                                wcnt <= wcnt + WW'(1);
                            end
                        end
                    end else if (tmo == TW'(IDLE_TMO - 1)) begin
                        state <= IDLE;
                        wcnt  <= '0;
                        tmo   <= '0;
                        rr    <= rr_next;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                IGNT: begin
                    if (done || !bus.iREN[gidx]) begin
                        state <= IDLE;
                        rr    <= rr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
